serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 Port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 Port: done  output  1  one-cycle pulse marking valid results.
REQ-009 Port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 Port: borrow_out  output  1  high when unsigned a < b.
REQ-011 Port: overflow  output  1  signed (two's complement) overflow of a - b.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE -> RUN on a rising edge with start=1; a and b latched into shift registers, borrow register cleared, bit counter cleared, diff register cleared.
REQ-014 start=1 in RUN or DONE SHALL be ignored, with no effect on operands or results.
REQ-015 Each RUN edge SHALL process one bit, LSB first: d = a0 XOR b0 XOR br; br_next = (NOT a0 AND b0) OR (NOT(a0 XOR b0) AND br).
REQ-016 Each RUN edge SHALL shift both operand registers right by one bit and shift d into diff at the MSB end, so that after WIDTH bits diff holds the result in natural order.
REQ-017 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide; RUN -> DONE on the edge that processes bit WIDTH-1; RUN SHALL last exactly WIDTH cycles.
REQ-018 borrow_out SHALL be loaded with br_next of the final bit on the RUN -> DONE edge.
REQ-019 overflow SHALL be loaded on the RUN -> DONE edge with (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]), using the values of a and b captured at start.
REQ-020 done SHALL be high only in DONE (one cycle); DONE -> IDLE unconditionally on the next edge.
REQ-021 Latency: start accepted at edge E0 -> done high in the cycle following edge E(WIDTH+1)-1 = EWIDTH, i.e. WIDTH+1 cycles after start is sampled.
REQ-022 busy SHALL be 0 in IDLE and 1 in RUN and DONE; a new start is accepted at the earliest on the edge after done falls.
REQ-023 diff, borrow_out and overflow SHALL hold their values from done until the next accepted start; intermediate diff values during RUN are not valid and SHALL NOT be relied on.
REQ-024 All outputs SHALL be registered, with no combinational path from start, a or b to any output.

Reset
REQ-025 rst=1 SHALL immediately force: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0, counter=0, operand registers=0, br=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; after release, the first accepted start SHALL produce a correct result.
REQ-027 start held high during reset SHALL NOT be accepted until the first rising edge after rst deasserts.

Verification
REQ-028 WIDTH=8, a=0x05, b=0x03, start pulse -> busy for 9 cycles, done one cycle, diff=0x02, borrow_out=0, overflow=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
REQ-030 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
REQ-031 a=0x00, b=0x00 -> diff=0x00, borrow_out=0, overflow=0; start held high continuously -> back-to-back operations spaced WIDTH+2 cycles apart, with each done a single cycle.
REQ-032 Start an operation with a=0xAA, b=0x55, change a/b and pulse start during RUN -> result still 0x55, borrow_out=0; the second start is ignored.
REQ-033 Assert rst on the 4th RUN cycle -> all outputs 0 immediately, no done pulse; then a=0x10, b=0x20 -> diff=0xF0, borrow_out=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor computing a - b with borrow and signed overflow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    // Operand sign bits are kept separately because the shift registers lose them.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic a0, b0, d_bit, br_next;

    always_comb begin
        a0      = a_sh_q[0];
        b0      = b_sh_q[0];
        d_bit   = a0 ^ b0 ^ br_q;
        br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    diff_d  = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    borrow_d = br_next;
                    ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with directed vectors
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out, overflow;
    logic [W-1:0] diff;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   done_times[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   run_len = 0;
    logic prev_done = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff),
        .borrow_out(borrow_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: sample mid-cycle, pop the scoreboard on each done pulse.
    always @(negedge clk) begin
        cyc++;
        if (rst || !busy) run_len = 0;
        else run_len++;
        if (done) begin
            exp_t e;
            done_times.push_back(cyc);
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            check("busy_cycles", run_len, W + 1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got diff %0h expected no done", diff);
            end else begin
                e = sb.pop_front();
                check("diff", {24'd0, diff}, {24'd0, e.d});
                check("borrow_out", {31'd0, borrow_out}, {31'd0, e.br});
                check("overflow", {31'd0, overflow}, {31'd0, e.ov});
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("timeout_busy", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        sb.push_back('{d: ed, br: eb, ov: eo});
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_diff", {24'd0, diff}, 32'd0);
        check("reset_borrow", {31'd0, borrow_out}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Start held high: two back-to-back operations.
        done_times.delete();
        sb.push_back('{d: 8'h0E, br: 1'b0, ov: 1'b0});
        sb.push_back('{d: 8'h0E, br: 1'b0, ov: 1'b0});
        a = 8'h11; b = 8'h03; start = 1'b1;
        for (int n = 0; n < 60 && done_times.size() < 2; n++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (done_times.size() >= 2)
            check("b2b_spacing", done_times[1] - done_times[0], W + 2);
        else
            check("b2b_timeout", done_times.size(), 2);
        wait_idle();
        @(posedge clk); #1;

        // Second start during RUN with changed operands must be ignored.
        sb.push_back('{d: 8'h55, br: 1'b0, ov: 1'b1});
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        a = 8'h01; b = 8'hFE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (3) begin @(posedge clk); #1; end
        check("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Reset during the 4th RUN cycle aborts without a done pulse.
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_borrow", {31'd0, borrow_out}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);

        repeat (5) begin @(posedge clk); #1; end
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
